// File: rtl/spart_pkg.sv
// Shared types and constants for the SPART sequencing controller:
// FSM states, baud switch encodings and the 16-bit divisor table.
package spart_pkg;

    typedef enum logic [1:0] {
        CFG_LOW  = 2'd0,
        CFG_HIGH = 2'd1,
        RUN      = 2'd2,
        DRAIN    = 2'd3
    } ctrlState_t;

    localparam logic [1:0] BR_CFG_4800  = 2'b00;
    localparam logic [1:0] BR_CFG_9600  = 2'b01;
    localparam logic [1:0] BR_CFG_19200 = 2'b10;
    localparam logic [1:0] BR_CFG_38400 = 2'b11;

    // divisor = 100 MHz / (16 * baud) - 1
    localparam logic [15:0] DIV_4800  = 16'h0515;
    localparam logic [15:0] DIV_9600  = 16'h028A;
    localparam logic [15:0] DIV_19200 = 16'h0145;
    localparam logic [15:0] DIV_38400 = 16'h00A2;

    function automatic logic [15:0] divisorFor(input logic [1:0] cfg);
        case (cfg)
            BR_CFG_4800:  divisorFor = DIV_4800;
            BR_CFG_9600:  divisorFor = DIV_9600;
            BR_CFG_19200: divisorFor = DIV_19200;
            default:      divisorFor = DIV_38400;
        endcase
    endfunction

endpackage

// File: rtl/echo_fifo.sv
// Circular byte FIFO with first-word fall-through output; a push while full
// is only accepted when a pop frees the head slot in the same cycle.
module echo_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [7:0]               din,
    output logic [7:0]               dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    logic          w_doPush;
    logic          w_doPop;

    assign empty    = (r_count == '0);
    assign full     = (r_count == FULL_COUNT);
    assign w_doPop  = pop && !empty;
    assign w_doPush = push && (!full || w_doPop);
    assign dout     = r_mem[r_rdPtr];
    assign count    = r_count;

    always_ff @(posedge clk) begin
        if (w_doPush) begin
            r_mem[r_wrPtr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_doPush) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_doPop) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/spart_ctrl.sv
// SPART sequencer: loads the baud divisor low/high byte from the synced switches,
// then echoes received bytes to the transmitter through a small FIFO.
module spart_ctrl
    import spart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TX_HOLDOFF = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [1:0]                    br_cfg,
    output logic [7:0]                    baud_data,
    output logic                          baud_sel_low,
    output logic                          baud_sel_high,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_rda,
    output logic                          rx_rd,
    output logic [7:0]                    tx_data,
    output logic                          tx_wrt,
    input  logic                          tx_tbr,
    output logic                          cfg_done,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int HW = (TX_HOLDOFF > 0) ? $clog2(TX_HOLDOFF + 1) : 1;
    localparam logic [HW-1:0] HOLDOFF_LOAD = HW'(TX_HOLDOFF);

    logic [1:0]    r_cfgMeta;
    logic [1:0]    r_cfgSync;
    logic [1:0]    r_cfgLatched;
    ctrlState_t    r_state;
    ctrlState_t    w_nextState;
    logic [HW-1:0] r_holdoff;
    logic [7:0]    r_baudData;
    logic [7:0]    r_txData;
    logic          r_selLow;
    logic          r_selHigh;
    logic          r_cfgDone;
    logic          r_rxRd;
    logic          r_txWrt;
    logic          r_overflow;
    logic [7:0]    w_baudDataNext;
    logic          w_selLowNext;
    logic          w_selHighNext;
    logic          w_cfgDoneNext;
    logic          w_rxAccept;
    logic          w_txFire;
    logic          w_holdoffClear;
    logic          w_fifoFull;
    logic          w_fifoEmpty;
    logic [7:0]    w_fifoDout;
    logic [15:0]   w_divisor;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cfgMeta <= '0;
            r_cfgSync <= '0;
        end else begin
            r_cfgMeta <= br_cfg;
            r_cfgSync <= r_cfgMeta;
        end
    end

    // The configuration is captured while in CFG_LOW so both bytes match.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= CFG_LOW;
            r_cfgLatched <= BR_CFG_4800;
        end else begin
            r_state <= w_nextState;
            if (r_state == CFG_LOW) begin
                r_cfgLatched <= r_cfgSync;
            end
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            CFG_LOW:  w_nextState = CFG_HIGH;
            CFG_HIGH: w_nextState = RUN;
            RUN:      if (r_cfgSync != r_cfgLatched) w_nextState = DRAIN;
            DRAIN:    if (w_holdoffClear && tx_tbr) w_nextState = CFG_LOW;
        endcase
    end

    assign w_holdoffClear = (r_holdoff == '0);
    assign w_rxAccept     = rx_rda && !r_rxRd;
    assign w_txFire       = (r_state == RUN) && !w_fifoEmpty && tx_tbr && w_holdoffClear;
    assign w_divisor      = divisorFor((r_state == CFG_LOW) ? r_cfgSync : r_cfgLatched);

    always_comb begin
        w_baudDataNext = r_baudData;
        w_selLowNext   = 1'b0;
        w_selHighNext  = 1'b0;
        w_cfgDoneNext  = 1'b0;
        case (r_state)
            CFG_LOW: begin
                w_selLowNext   = 1'b1;
                w_baudDataNext = w_divisor[7:0];
            end
            CFG_HIGH: begin
                w_selHighNext  = 1'b1;
                w_baudDataNext = w_divisor[15:8];
            end
            RUN:     w_cfgDoneNext = 1'b1;
            default: w_cfgDoneNext = 1'b0;
        endcase
    end

    // Outputs lag the state by one edge, so every port comes straight from a flop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_baudData <= '0;
            r_selLow   <= 1'b0;
            r_selHigh  <= 1'b0;
            r_cfgDone  <= 1'b0;
            r_rxRd     <= 1'b0;
            r_txWrt    <= 1'b0;
            r_txData   <= '0;
            r_overflow <= 1'b0;
            r_holdoff  <= '0;
        end else begin
            r_baudData <= w_baudDataNext;
            r_selLow   <= w_selLowNext;
            r_selHigh  <= w_selHighNext;
            r_cfgDone  <= w_cfgDoneNext;
            r_rxRd     <= w_rxAccept;
            r_txWrt    <= w_txFire;
            if (w_txFire) begin
                r_txData <= w_fifoDout;
            end
            if (w_rxAccept && w_fifoFull && !w_txFire) begin
                r_overflow <= 1'b1;
            end
            if (w_txFire) begin
                r_holdoff <= HOLDOFF_LOAD;
            end else if (!w_holdoffClear) begin
                r_holdoff <= r_holdoff - 1'b1;
            end
        end
    end

    echo_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_echoFifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_rxAccept),
        .pop   (w_txFire),
        .din   (rx_data),
        .dout  (w_fifoDout),
        .full  (w_fifoFull),
        .empty (w_fifoEmpty),
        .count (fifo_count)
    );

    assign baud_data     = r_baudData;
    assign baud_sel_low  = r_selLow;
    assign baud_sel_high = r_selHigh;
    assign rx_rd         = r_rxRd;
    assign tx_data       = r_txData;
    assign tx_wrt        = r_txWrt;
    assign cfg_done      = r_cfgDone;
    assign overflow      = r_overflow;

endmodule

// File: tb/tb_spart_ctrl.sv
// Scoreboard bench for spart_ctrl: expected echo bytes are queued when rx stimulus
// is driven and popped when tx_wrt fires; strobes and status are checked directly.
module tb_spart_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] br_cfg = 2'b00;
    logic [7:0] rx_data = 8'h00;
    logic       rx_rda = 1'b0;
    logic       tx_tbr = 1'b0;
    logic [7:0] baud_data;
    logic       baud_sel_low;
    logic       baud_sel_high;
    logic       rx_rd;
    logic [7:0] tx_data;
    logic       tx_wrt;
    logic       cfg_done;
    logic       overflow;
    logic [2:0] fifo_count;

    int          checkCount = 0;
    int          failCount = 0;
    logic [7:0]  expQ[$];
    logic [7:0]  expByte;
    int          rxRdCount = 0;
    int          txWrtCount = 0;
    int          selLowCount = 0;
    int          selHighCount = 0;
    logic        prevRxRd = 1'b0;
    logic [15:0] modelDivisor = 16'h0000;
    int          snapA;
    int          snapB;
    int          snapC;
    bit          seenStrobe;

    spart_ctrl #(
        .FIFO_DEPTH (4),
        .TX_HOLDOFF (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .br_cfg        (br_cfg),
        .baud_data     (baud_data),
        .baud_sel_low  (baud_sel_low),
        .baud_sel_high (baud_sel_high),
        .rx_data       (rx_data),
        .rx_rda        (rx_rda),
        .rx_rd         (rx_rd),
        .tx_data       (tx_data),
        .tx_wrt        (tx_wrt),
        .tx_tbr        (tx_tbr),
        .cfg_done      (cfg_done),
        .overflow      (overflow),
        .fifo_count    (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".baudData"}, 32'(baud_data), 0);
        checkOutput({tag, ".selLow"}, 32'(baud_sel_low), 0);
        checkOutput({tag, ".selHigh"}, 32'(baud_sel_high), 0);
        checkOutput({tag, ".rxRd"}, 32'(rx_rd), 0);
        checkOutput({tag, ".txData"}, 32'(tx_data), 0);
        checkOutput({tag, ".txWrt"}, 32'(tx_wrt), 0);
        checkOutput({tag, ".cfgDone"}, 32'(cfg_done), 0);
        checkOutput({tag, ".overflow"}, 32'(overflow), 0);
        checkOutput({tag, ".fifoCount"}, 32'(fifo_count), 0);
    endtask

    // rx model: hold rda until the read acknowledge, then drop it within a cycle.
    task automatic applyStimulus(input logic [7:0] b, input bit accepted);
        bit seen;
        seen = 1'b0;
        rx_data = b;
        rx_rda  = 1'b1;
        if (accepted) expQ.push_back(b);
        for (int i = 0; i < 20 && !seen; i++) begin
            tick(1);
            if (rx_rd) seen = 1'b1;
        end
        checkOutput("rxRdSeen", 32'(seen), 1);
        rx_rda = 1'b0;
        tick(1);
    endtask

    task automatic drainAndCheck(input string tag, input int maxCycles);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < maxCycles) begin
            tick(1);
            n++;
        end
        checkOutput({tag, ".queueEmpty"}, 32'(expQ.size()), 0);
        tick(3);
        checkOutput({tag, ".fifoCount"}, 32'(fifo_count), 0);
    endtask

    // Monitor: tx scoreboard, rx_rd spacing, and a baud_rate_gen divisor model.
    always @(negedge clk) begin
        if (rst) begin
            if (rx_rd) begin
                rxRdCount++;
                checkOutput("rxRdGap", 32'(prevRxRd), 0);
            end
            if (tx_wrt) begin
                txWrtCount++;
                if (expQ.size() == 0) begin
                    checkOutput("txUnexpected", 32'(tx_data), 32'h100);
                end else begin
                    expByte = expQ.pop_front();
                    checkOutput("txByte", 32'(tx_data), 32'(expByte));
                end
            end
            if (baud_sel_low) begin
                selLowCount++;
                modelDivisor[7:0] = baud_data;
            end
            if (baud_sel_high) begin
                selHighCount++;
                modelDivisor[15:8] = baud_data;
            end
        end
        prevRxRd = rx_rd;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        tick(3);
        checkAllZero("reset");

        rst = 1'b1;
        tick(1);
        checkOutput("boot.selLow", 32'(baud_sel_low), 1);
        checkOutput("boot.lowByte", 32'(baud_data), 32'h15);
        checkOutput("boot.selHighEarly", 32'(baud_sel_high), 0);
        tick(1);
        checkOutput("boot.selHigh", 32'(baud_sel_high), 1);
        checkOutput("boot.highByte", 32'(baud_data), 32'h05);
        checkOutput("boot.selLowClear", 32'(baud_sel_low), 0);
        checkOutput("boot.cfgDoneEarly", 32'(cfg_done), 0);
        tick(1);
        checkOutput("boot.cfgDone", 32'(cfg_done), 1);
        checkOutput("boot.divisor", 32'(modelDivisor), 32'h0515);

        tx_tbr = 1'b1;
        snapA = txWrtCount;
        snapB = rxRdCount;
        applyStimulus(8'h40, 1'b1);
        applyStimulus(8'h55, 1'b1);
        applyStimulus(8'hAA, 1'b1);
        drainAndCheck("echo", 50);
        checkOutput("echo.txCount", 32'(txWrtCount - snapA), 3);
        checkOutput("echo.rxCount", 32'(rxRdCount - snapB), 3);
        checkOutput("echo.txHold", 32'(tx_data), 32'hAA);

        tx_tbr = 1'b0;
        applyStimulus(8'h01, 1'b1);
        applyStimulus(8'h02, 1'b1);
        applyStimulus(8'h03, 1'b1);
        applyStimulus(8'h04, 1'b1);
        checkOutput("fullPair.countBefore", 32'(fifo_count), 4);
        rx_data = 8'h99;
        rx_rda  = 1'b1;
        tx_tbr  = 1'b1;
        expQ.push_back(8'h99);
        tick(1);
        checkOutput("fullPair.txWrt", 32'(tx_wrt), 1);
        checkOutput("fullPair.rxRd", 32'(rx_rd), 1);
        checkOutput("fullPair.count", 32'(fifo_count), 4);
        checkOutput("fullPair.overflow", 32'(overflow), 0);
        rx_rda = 1'b0;
        drainAndCheck("fullPair", 60);
        checkOutput("fullPair.overflowAfter", 32'(overflow), 0);

        tx_tbr = 1'b0;
        snapB = rxRdCount;
        applyStimulus(8'h10, 1'b1);
        applyStimulus(8'h20, 1'b1);
        applyStimulus(8'h30, 1'b1);
        applyStimulus(8'h40, 1'b1);
        applyStimulus(8'h50, 1'b0);
        checkOutput("ovf.count", 32'(fifo_count), 4);
        checkOutput("ovf.flag", 32'(overflow), 1);
        checkOutput("ovf.rxCount", 32'(rxRdCount - snapB), 5);
        snapA = txWrtCount;
        tx_tbr = 1'b1;
        drainAndCheck("ovf", 60);
        checkOutput("ovf.txCount", 32'(txWrtCount - snapA), 4);
        checkOutput("ovf.sticky", 32'(overflow), 1);

        tx_tbr = 1'b0;
        applyStimulus(8'h11, 1'b1);
        applyStimulus(8'h22, 1'b1);
        snapA = selLowCount;
        snapB = selHighCount;
        snapC = txWrtCount;
        br_cfg = 2'b11;
        tick(10);
        checkOutput("recfg.cfgDoneLow", 32'(cfg_done), 0);
        checkOutput("recfg.noSelLow", 32'(selLowCount - snapA), 0);
        checkOutput("recfg.noSelHigh", 32'(selHighCount - snapB), 0);
        checkOutput("recfg.noTx", 32'(txWrtCount - snapC), 0);
        checkOutput("recfg.retained", 32'(fifo_count), 2);
        tx_tbr = 1'b1;
        seenStrobe = 1'b0;
        for (int i = 0; i < 10 && !seenStrobe; i++) begin
            tick(1);
            if (baud_sel_low) seenStrobe = 1'b1;
        end
        checkOutput("recfg.selLowSeen", 32'(seenStrobe), 1);
        checkOutput("recfg.lowByte", 32'(baud_data), 32'hA2);
        tick(1);
        checkOutput("recfg.selHigh", 32'(baud_sel_high), 1);
        checkOutput("recfg.highByte", 32'(baud_data), 32'h00);
        tick(1);
        checkOutput("recfg.cfgDone", 32'(cfg_done), 1);
        checkOutput("recfg.divisor", 32'(modelDivisor), 32'h00A2);
        drainAndCheck("recfg", 50);

        br_cfg = 2'b00;
        tick(8);
        rst = 1'b0;
        tick(1);
        rst = 1'b1;
        tick(1);
        checkOutput("midCfg.selLow", 32'(baud_sel_low), 1);
        tick(1);
        checkOutput("midCfg.selHigh", 32'(baud_sel_high), 1);
        #2;
        rst = 1'b0;
        #1;
        checkAllZero("midCfg");
        tick(1);
        rst = 1'b1;
        tick(1);
        checkOutput("midCfg.restartSelLow", 32'(baud_sel_low), 1);
        checkOutput("midCfg.restartLowByte", 32'(baud_data), 32'h15);
        tick(2);
        checkOutput("midCfg.cfgDone", 32'(cfg_done), 1);

        tx_tbr = 1'b0;
        applyStimulus(8'h61, 1'b1);
        applyStimulus(8'h62, 1'b1);
        applyStimulus(8'h63, 1'b1);
        checkOutput("midEcho.countBefore", 32'(fifo_count), 3);
        #2;
        rst = 1'b0;
        #1;
        checkAllZero("midEcho");
        expQ.delete();
        tick(1);
        rst = 1'b1;
        snapA = txWrtCount;
        tick(1);
        checkOutput("midEcho.restartSelLow", 32'(baud_sel_low), 1);
        checkOutput("midEcho.fifoEmpty", 32'(fifo_count), 0);
        tick(2);
        checkOutput("midEcho.cfgDone", 32'(cfg_done), 1);
        tx_tbr = 1'b1;
        tick(10);
        checkOutput("midEcho.noTx", 32'(txWrtCount - snapA), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/spart_ctrl.md
# spart_ctrl

Sequencing controller for the SPART datapath. It programs the baud rate generator's 16-bit divisor from the `br_cfg` switches, byte-serially: low byte, then high byte. It then runs an echo loop: bytes accepted from `rx` go into a small FIFO, and the FIFO drains into `tx`. It sits in `top_level` between the switch inputs and the `baud_rate_gen`/`tx`/`rx` instances, replacing ad-hoc driving of `sel_low`/`sel_high`/`en_tx`/`rd_rx`.

## Interface
- `FIFO_DEPTH`, 4: echo buffer entries; must be a power of two, at least 2.
- `TX_HOLDOFF`, 2: cycles after a `tx_wrt` pulse during which `tx_tbr` is ignored.
- `clk` in 1: system clock, 100 MHz.
- `rst` in 1: asynchronous, active-low reset.
- `br_cfg` in 2: baud select from dip switches; asynchronous to `clk`.
- `baud_data` out 8: divisor byte to `baud_rate_gen.data`.
- `baud_sel_low` out 1: load strobe for the divisor low byte.
- `baud_sel_high` out 1: load strobe for the divisor high byte.
- `rx_data` in 8: received byte from `rx.RxD_data`.
- `rx_rda` in 1: receive data available.
- `rx_rd` out 1: one-cycle read acknowledge to `rx.rd_rx`.
- `tx_data` out 8: byte to `tx.data`.
- `tx_wrt` out 1: one-cycle transmit strobe to `tx.en_tx`.
- `tx_tbr` in 1: transmit buffer ready.
- `cfg_done` out 1: high while the divisor is programmed and the echo loop is running.
- `overflow` out 1: sticky; set when a byte is dropped because the FIFO is full.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.

## Operation
- **br_cfg input:** passes through a two-flop synchronizer; all logic uses the synced value `cfg_s`.
- **Divisor table:** divisor = 100e6/(16*baud) - 1.
  - 00 → 4800 baud → 0x0515
  - 01 → 9600 baud → 0x028A
  - 10 → 19200 baud → 0x0145
  - 11 → 38400 baud → 0x00A2
- **State machine:** states are CFG_LOW, CFG_HIGH, RUN, DRAIN.
  - CFG_LOW: `baud_sel_low`=1, `baud_data`=divisor[7:0]; goes to CFG_HIGH next cycle.
  - CFG_HIGH: `baud_sel_high`=1, `baud_data`=divisor[15:8]; goes to RUN next cycle. The divisor is latched from `cfg_s` on entry to CFG_LOW.
  - RUN: `cfg_done`=1. If `cfg_s` differs from the latched config, go to DRAIN.
  - DRAIN: `cfg_done`=0. Receive is still serviced; no new `tx_wrt` is issued. Go to CFG_LOW when the holdoff has expired and `tx_tbr`=1. FIFO contents are retained across reconfiguration.
- **Receive path (all states):**
  - If `rx_rda`=1 and `rx_rd` was low last cycle, pulse `rx_rd` and push `rx_data` in that same cycle.
  - `rx_rd` is never high on two consecutive cycles.
- **FIFO full:**
  - On full with no pop that cycle, `rx_rd` still pulses, the byte is discarded, and `overflow` is set.
  - On full with a simultaneous pop, the push is accepted and `fifo_count` is unchanged.
- **Transmit path (RUN only):** when the FIFO is non-empty, `tx_tbr`=1 and the holdoff counter is 0:
  - `tx_wrt` pulses for one cycle with `tx_data` = FIFO head, and the head is popped.
  - The holdoff counter loads `TX_HOLDOFF`.
  - `tx_data` holds its value until the next write.
- **FIFO storage:** circular buffer; read and write pointers wrap modulo `FIFO_DEPTH`.
- **Reset:** assertion at any point, including mid-configuration or mid-transmit, clears the FIFO, `overflow` and the holdoff counter. Release enters CFG_LOW.

## Timing
- **Reset values:** all outputs are 0. `baud_data`=0x00, `tx_data`=0x00, `fifo_count`=0, `cfg_done`=0, `overflow`=0.
- **Strobe timing:**
  - The first rising edge after `rst` deasserts drives `baud_sel_low`.
  - The next edge drives `baud_sel_high`.
  - The edge after that raises `cfg_done`.
- **Switch change to reconfiguration:** 2 cycles (synchronizer) + 1 (compare) to DRAIN, then DRAIN duration, then 2 strobe cycles.
- **Echo latency:**
  - `rx_rda` rising → `rx_rd` on the next cycle.
  - Empty FIFO → `tx_wrt` at the earliest 1 cycle after the push.
- **Handshake assumptions:** `rx` drops `rx_rda` within 1 cycle of `rx_rd`; `tx` drops `tx_tbr` within `TX_HOLDOFF` cycles of `tx_wrt`.
- **Registering:** all outputs are registered; none depends combinationally on an input.

## Structure
- **Package `spart_pkg`:**
  - state enum (CFG_LOW, CFG_HIGH, RUN, DRAIN)
  - `br_cfg` encodings
  - 16-bit divisor constants
  - divisor lookup function
- **Sub-module `echo_fifo`:**
  - parameter `DEPTH`
  - ports: push, pop, din, dout, full, empty, count
  - first-word fall-through output; push while full is ignored internally unless a pop occurs in the same cycle
- **`spart_ctrl`:** FSM, synchronizer, holdoff counter, rx/tx handshake logic.

## Test plan
- **Reset release with `br_cfg`=00:** `baud_sel_low` with 0x15 at cycle 1, `baud_sel_high` with 0x05 at cycle 2, `cfg_done`=1 at cycle 3. A `baud_rate_gen` model holds 0x0515.
- **Change `br_cfg` 00→11 in RUN while `tx_tbr`=0:** no strobes until `tx_tbr`=1, then 0xA2 followed by 0x00. Existing FIFO bytes are retained and sent after `cfg_done` returns.
- **Echo through loopback (rx/tx models, `tx_tbr` held 1):** rx presents 0x40, 0x55, 0xAA. `tx_wrt` fires three times with the same bytes in order; `rx_rd` pulses are never adjacent.
- **Overflow (`tx_tbr` held 0):** five bytes pushed with `FIFO_DEPTH`=4. `fifo_count`=4, `overflow`=1, five `rx_rd` pulses. After `tx_tbr`=1, exactly the first four bytes are sent.
- **Push and pop in the same cycle at full:** `rx_rda` and a pop coincide. `fifo_count` stays 4, `overflow` stays 0, and the new byte is transmitted last.
- **Reset asserted mid-configuration (during CFG_HIGH) and mid-echo (`fifo_count`=3):** all outputs go to 0 immediately, without waiting for a clock edge. On release the divisor load sequence restarts and the FIFO is empty.
